// File: rtl/sram_responder_pkg.sv
// Shared definitions for the asynchronous SRAM bus and its responder.
// Phase codes match the SRAM controllers so the responder's registered
// phase can be compared directly against controller state.
package sram_pkg;

  localparam int ADDR_W = 18;  // word address width on the bus
  localparam int DATA_W = 16;  // data bus width (two byte lanes)

  typedef enum logic [1:0] {
    PH_WRITE = 2'b00,
    PH_READ  = 2'b01,
    PH_IDLE  = 2'b11
  } phase_t;

endpackage

// File: rtl/sram_responder_if.sv
// Pin bundle of the 16-bit asynchronous SRAM bus.
//   CE, OE, WE, LB, UB : active-low strobes driven by the master
//   A                  : word address driven by the master
//   D                  : shared tristate data bus
//   wdata / wdata_en   : master-side drive of D (released when wdata_en=0)
//   lane_drive         : responder's per-lane drive enables {upper, lower}
interface sram_if;
  import sram_pkg::*;

  logic              CE;
  logic              OE;
  logic              WE;
  logic              LB;
  logic              UB;
  logic [ADDR_W-1:0] A;
  wire  [DATA_W-1:0] D;

  logic [DATA_W-1:0] wdata;
  logic              wdata_en;
  logic [1:0]        lane_drive;

  assign D = wdata_en ? wdata : {DATA_W{1'bz}};

  modport master (
    output CE, OE, WE, LB, UB, A, wdata, wdata_en,
    input  lane_drive,
    inout  D
  );

  modport slave (
    input  CE, OE, WE, LB, UB, A,
    output lane_drive,
    inout  D
  );
endinterface

// File: rtl/sram_responder.sv
// Pin-level stand-in for an external asynchronous 16-bit SRAM.
// Flop-based memory of 2**ADDR_BITS words aliased over the 18-bit address
// space, zero-latency reads onto D, byte-masked writes at the clock edge,
// plus a registered phase tracker, saturating access counters and a sticky
// lane error flag for debug.
// Ports:
//   clk      : system clock
//   rst      : asynchronous active-low reset
//   bus      : SRAM pin bundle (slave side)
//   phase    : registered bus phase (WRITE=00, READ=01, IDLE=11)
//   wr_count : distinct write accesses, saturating
//   rd_count : distinct read accesses, saturating
//   err      : sticky, access seen with both byte lanes disabled
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  sram_if.slave            bus,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic             err
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [ADDR_BITS-1:0] idx;
  logic [DATA_W-1:0]    rd_word;
  phase_t               cls;
  phase_t               phase_reg, phase_next;
  logic [ADDR_W-1:0]    last_a_reg;
  logic                 new_access;
  logic                 rd_lo, rd_hi;

  assign idx     = bus.A[ADDR_BITS-1:0];
  assign rd_word = mem[idx];

  // Pin classification of the current cycle.
  always_comb begin
    cls = PH_IDLE;
    if (!bus.CE) cls = bus.WE ? PH_READ : PH_WRITE;
  end

  // Read drive is purely combinational so the master can sample D at the
  // same edge it presents the read. Held off during reset.
  assign rd_lo = rst && (cls == PH_READ) && !bus.OE && !bus.LB;
  assign rd_hi = rst && (cls == PH_READ) && !bus.OE && !bus.UB;
  assign bus.lane_drive = {rd_hi, rd_lo};
  assign bus.D[7:0]     = rd_lo ? rd_word[7:0]  : 8'hzz;
  assign bus.D[15:8]    = rd_hi ? rd_word[15:8] : 8'hzz;

  // Byte-masked write; a held write rewrites the word every cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (cls == PH_WRITE) begin
      if (!bus.LB) mem[idx][7:0]  <= bus.D[7:0];
      if (!bus.UB) mem[idx][15:8] <= bus.D[15:8];
    end
  end

  // Phase tracker: the next phase is simply this cycle's classification.
  always_comb begin
    phase_next = cls;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg  <= PH_IDLE;
      last_a_reg <= '0;
    end else begin
      phase_reg  <= phase_next;
      last_a_reg <= bus.A;
    end
  end

  assign phase = phase_reg;

  // A new access starts whenever the bus leaves idle, flips direction or
  // moves to another address; holding the same access is counted once.
  assign new_access = (cls != PH_IDLE) && ((cls != phase_reg) || (bus.A != last_a_reg));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
      rd_count <= '0;
      err      <= 1'b0;
    end else begin
      if (new_access && (cls == PH_WRITE) && (wr_count != {CNT_W{1'b1}}))
        wr_count <= wr_count + 1'b1;
      if (new_access && (cls == PH_READ) && (rd_count != {CNT_W{1'b1}}))
        rd_count <= rd_count + 1'b1;
      if (!bus.CE && bus.LB && bus.UB)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: drives the SRAM pins step by step and
// checks D, lane drive enables, phase, counters and the sticky error flag.
module tb_sram_responder;
  import sram_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  phase;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic        err;
  int          errors;
  int          checks;

  sram_if bus ();

  sram_responder #(.ADDR_BITS(6), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .phase    (phase),
    .wr_count (wr_count),
    .rd_count (rd_count),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pins(input logic ce, input logic oe, input logic we, input logic lb,
                      input logic ub, input logic [17:0] a, input logic [15:0] wd,
                      input logic wen);
    bus.CE = ce; bus.OE = oe; bus.WE = we; bus.LB = lb; bus.UB = ub;
    bus.A = a; bus.wdata = wd; bus.wdata_en = wen;
  endtask

  task automatic idle();
    pins(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 18'd0, 16'h0000, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    idle();
    tick(); tick();
    chk("rst_lanes", {30'd0, bus.lane_drive}, 32'd0);
    chk("rst_phase", {30'd0, phase}, 32'h3);
    chk("rst_wr", {16'd0, wr_count}, 32'd0);
    chk("rst_rd", {16'd0, rd_count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    tick();
    chk("idle_phase", {30'd0, phase}, 32'h3);
    chk("idle_lanes", {30'd0, bus.lane_drive}, 32'd0);

    // Single-cycle write then same-cycle read at A=100.
    pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'd100, 16'h0006, 1'b1);
    tick();
    chk("wr_phase", {30'd0, phase}, 32'h0);
    chk("wr_cnt1", {16'd0, wr_count}, 32'd1);
    pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd100, 16'h0000, 1'b0);
    #1;
    chk("rd100_lanes", {30'd0, bus.lane_drive}, 32'h3);
    chk("rd100_D", {16'd0, bus.D}, 32'h0006);
    tick();
    chk("rd_phase", {30'd0, phase}, 32'h1);
    chk("rd_cnt1", {16'd0, rd_count}, 32'd1);

    // Aliasing: 0x10000 and 0x20000 both map to idx 0.
    pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h10000, 16'h0004, 1'b1);
    tick();
    pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'h20000, 16'h0002, 1'b1);
    tick();
    chk("alias_wr_cnt", {16'd0, wr_count}, 32'd3);
    pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd0, 16'h0000, 1'b0);
    #1;
    chk("alias_rd0", {16'd0, bus.D}, 32'h0002);
    tick();
    pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd1000, 16'h0000, 1'b0);
    #1;
    chk("rd_idx40", {16'd0, bus.D}, 32'h0000);
    tick();
    chk("alias_rd_cnt", {16'd0, rd_count}, 32'd3);

    // Byte lanes: second write at same A only touches the lower byte and
    // is the same access, so wr_count does not move.
    pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'd5, 16'hABCD, 1'b1);
    tick();
    pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 18'd5, 16'h1234, 1'b1);
    tick();
    chk("lane_wr_cnt", {16'd0, wr_count}, 32'd4);
    pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd5, 16'h0000, 1'b0);
    #1;
    chk("lane_rd_full", {16'd0, bus.D}, 32'hAB34);
    tick();
    pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 18'd5, 16'h0000, 1'b0);
    #1;
    chk("lane_lb_off", {30'd0, bus.lane_drive}, 32'h2);
    chk("lane_hi_byte", {24'd0, bus.D[15:8]}, 32'hAB);
    tick();
    chk("lane_rd_cnt", {16'd0, rd_count}, 32'd4);
    idle();
    tick();

    // Held read at A=7 for five cycles, OE released on the last one.
    pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd7, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    bus.OE = 1'b1;
    #1;
    chk("oe_off_lanes", {30'd0, bus.lane_drive}, 32'h0);
    tick();
    chk("held_rd_cnt", {16'd0, rd_count}, 32'd5);
    bus.OE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.A = 18'(8 + i);
      tick();
    end
    chk("walk_rd_cnt", {16'd0, rd_count}, 32'd8);

    // WE toggling under CE=0: write, read-after-write, write again.
    pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd3, 16'h5555, 1'b1);
    tick();
    pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd3, 16'h0000, 1'b0);
    #1;
    chk("raw_D", {16'd0, bus.D}, 32'h5555);
    tick();
    pins(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'd3, 16'h5555, 1'b1);
    tick();
    chk("tog_wr_cnt", {16'd0, wr_count}, 32'd6);
    chk("tog_rd_cnt", {16'd0, rd_count}, 32'd9);

    // Lane error: read strobe with both lanes off, counts but drives nothing.
    pins(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 18'd3, 16'h0000, 1'b0);
    #1;
    chk("err_lanes", {30'd0, bus.lane_drive}, 32'h0);
    tick();
    chk("err_set", {31'd0, err}, 32'd1);
    chk("err_rd_cnt", {16'd0, rd_count}, 32'd10);
    idle();
    tick(); tick();
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Async reset in the middle of a write cycle.
    pins(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 18'd3, 16'hFFFF, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_err", {31'd0, err}, 32'd0);
    chk("arst_wr", {16'd0, wr_count}, 32'd0);
    chk("arst_phase", {30'd0, phase}, 32'h3);
    idle();
    tick();
    rst = 1'b1;
    pins(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 18'd3, 16'h0000, 1'b0);
    #1;
    chk("arst_rd3", {16'd0, bus.D}, 32'h0000);
    tick();
    bus.A = 18'd100;
    #1;
    chk("arst_rd100", {16'd0, bus.D}, 32'h0000);
    tick();
    chk("arst_rd_cnt", {16'd0, rd_count}, 32'd2);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so a stuck simulation still terminates with a report.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
